// File: rtl/ika32010_pkg.sv
// Shared widths, constants and helpers for the IKA32010 bus target.
package ika32010_pkg;

    localparam int DATA_W     = 16;
    localparam int CPU_AW     = 12;
    localparam int PORT_CNT   = 8;
    localparam int PORT_SEL_W = 3;

    localparam logic [DATA_W-1:0] NOP_OPCODE = 16'h7F80;
    localparam logic [DATA_W-1:0] ERR_WORD   = 16'hFFFF;
    localparam logic [DATA_W-1:0] ZERO_WORD  = 16'h0000;

    // Source selected for the read data returned one cycle after the strobes.
    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_MEM  = 2'd1,
        RD_PIN  = 2'd2,
        RD_ERR  = 2'd3
    } rd_src_e;

    // True when a write to this address page targets the OUT-port registers.
    function automatic logic is_port_page(input logic [CPU_AW-PORT_SEL_W-1:0] page,
                                          input logic                         low_to_mem);
        return (page == {(CPU_AW-PORT_SEL_W){1'b0}}) && !low_to_mem;
    endfunction

endpackage

// File: rtl/ika32010_pmem.sv
// Single-port synchronous program RAM with registered read; a write also
// returns the written word on the read register (write-first).
module ika32010_pmem
    import ika32010_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Contents survive reset, so this array has no reset branch.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
            rdata_q       <= wdata_i;
        end else begin
            rdata_q       <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ika32010_bus_target.sv
// Memory/port target for the IKA32010 controller bus: program fetch, IN/OUT
// ports, table writes and a host-side program loader sharing one RAM port.
module ika32010_bus_target
    import ika32010_pkg::*;
#(
    parameter int MEM_AW      = 12,
    parameter int TBLW_LOW_EN = 0
) (
    input  logic                  i_EMUCLK,
    input  logic                  i_RST,
    input  logic                  i_MEN_n,
    input  logic                  i_DEN_n,
    input  logic                  i_WE_n,
    input  logic [CPU_AW-1:0]     i_AOUT,
    input  logic [DATA_W-1:0]     i_DOUT,
    output logic [DATA_W-1:0]     o_DIN,
    output logic                  o_DIN_OE,
    input  logic                  i_LD_VALID,
    output logic                  o_LD_READY,
    input  logic [MEM_AW-1:0]     i_LD_ADDR,
    input  logic [DATA_W-1:0]     i_LD_DATA,
    input  logic                  i_PIN_WR,
    input  logic [PORT_SEL_W-1:0] i_PIN_SEL,
    input  logic [DATA_W-1:0]     i_PIN_DATA,
    output logic                  o_POUT_STB,
    output logic [PORT_SEL_W-1:0] o_POUT_SEL,
    output logic [DATA_W-1:0]     o_POUT_DATA,
    output logic                  o_IN_ACK,
    output logic [PORT_SEL_W-1:0] o_IN_SEL,
    output logic                  o_BUS_ERR
);

    logic                  we_q, we_d;
    logic                  we_arm_q, we_arm_d;
    logic                  den_q, den_d;
    rd_src_e               rd_src_q, rd_src_d;
    logic [DATA_W-1:0]     pin_q [PORT_CNT];
    logic [DATA_W-1:0]     pin_rd_q, pin_rd_d;
    logic                  pout_stb_q, pout_stb_d;
    logic [PORT_SEL_W-1:0] pout_sel_q, pout_sel_d;
    logic [DATA_W-1:0]     pout_data_q, pout_data_d;
    logic                  in_ack_q, in_ack_d;
    logic [PORT_SEL_W-1:0] in_sel_q, in_sel_d;
    logic [PORT_SEL_W-1:0] in_port_q, in_port_d;
    logic                  bus_err_q, bus_err_d;

    logic                  wr_evt_s, port_wr_s, mem_wr_s;
    logic                  ld_ready_s, ld_fire_s;
    logic                  ram_we_s;
    logic [MEM_AW-1:0]     ram_addr_s;
    logic [DATA_W-1:0]     ram_wdata_s, ram_rdata_s;
    logic [DATA_W-1:0]     din_s;

    // we_arm_q blocks a write event until WE_n has been seen high after reset,
    // so a strobe held through reset cannot fire on release.
    assign wr_evt_s   = we_arm_q & we_q & ~i_WE_n;
    assign port_wr_s  = wr_evt_s & is_port_page(i_AOUT[CPU_AW-1:PORT_SEL_W], TBLW_LOW_EN != 0);
    assign mem_wr_s   = wr_evt_s & ~port_wr_s;
    assign ld_ready_s = ~i_RST & i_MEN_n & ~wr_evt_s;
    assign ld_fire_s  = i_LD_VALID & ld_ready_s;

    // RAM port arbitration: controller write, then loader, else fetch address.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_addr_s  = i_AOUT[MEM_AW-1:0];
        ram_wdata_s = i_DOUT;
        if (i_RST) begin
            ram_we_s = 1'b0;
        end else if (mem_wr_s) begin
            ram_we_s = 1'b1;
        end else if (ld_fire_s) begin
            ram_we_s    = 1'b1;
            ram_addr_s  = i_LD_ADDR;
            ram_wdata_s = i_LD_DATA;
        end else begin
            ram_we_s = 1'b0;
        end
    end

    ika32010_pmem #(
        .ADDR_W (MEM_AW)
    ) u_pmem (
        .clk_i   (i_EMUCLK),
        .we_i    (ram_we_s),
        .addr_i  (ram_addr_s),
        .wdata_i (ram_wdata_s),
        .rdata_o (ram_rdata_s)
    );

    // Next-state logic for strobe tracking, read source and port events.
    always_comb begin
        we_d     = i_WE_n;
        we_arm_d = we_arm_q | i_WE_n;
        den_d    = i_DEN_n;
        case ({i_MEN_n, i_DEN_n})
            2'b01:   rd_src_d = RD_MEM;
            2'b10:   rd_src_d = RD_PIN;
            2'b00:   rd_src_d = RD_ERR;
            default: rd_src_d = RD_IDLE;
        endcase
        pin_rd_d   = pin_q[i_AOUT[PORT_SEL_W-1:0]];
        pout_stb_d = port_wr_s;
        if (port_wr_s) begin
            pout_sel_d  = i_AOUT[PORT_SEL_W-1:0];
            pout_data_d = i_DOUT;
        end else begin
            pout_sel_d  = pout_sel_q;
            pout_data_d = pout_data_q;
        end
        if (i_DEN_n) begin
            in_port_d = in_port_q;
        end else begin
            in_port_d = i_AOUT[PORT_SEL_W-1:0];
        end
        in_ack_d = ~den_q & i_DEN_n;
        if (in_ack_d) begin
            in_sel_d = in_port_q;
        end else begin
            in_sel_d = in_sel_q;
        end
        bus_err_d = bus_err_q | (~i_MEN_n & ~i_DEN_n) | (~i_WE_n & (~i_MEN_n | ~i_DEN_n));
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            we_q        <= 1'b1;
            we_arm_q    <= 1'b0;
            den_q       <= 1'b1;
            rd_src_q    <= RD_IDLE;
            pin_rd_q    <= ZERO_WORD;
            pout_stb_q  <= 1'b0;
            pout_sel_q  <= 3'd0;
            pout_data_q <= ZERO_WORD;
            in_ack_q    <= 1'b0;
            in_sel_q    <= 3'd0;
            in_port_q   <= 3'd0;
            bus_err_q   <= 1'b0;
            for (int i = 0; i < PORT_CNT; i++) begin
                pin_q[i] <= ZERO_WORD;
            end
        end else begin
            we_q        <= we_d;
            we_arm_q    <= we_arm_d;
            den_q       <= den_d;
            rd_src_q    <= rd_src_d;
            pin_rd_q    <= pin_rd_d;
            pout_stb_q  <= pout_stb_d;
            pout_sel_q  <= pout_sel_d;
            pout_data_q <= pout_data_d;
            in_ack_q    <= in_ack_d;
            in_sel_q    <= in_sel_d;
            in_port_q   <= in_port_d;
            bus_err_q   <= bus_err_d;
            if (i_PIN_WR) begin
                pin_q[i_PIN_SEL] <= i_PIN_DATA;
            end
        end
    end

    // Read data mux over registered sources; RAM output is already registered.
    always_comb begin
        case (rd_src_q)
            RD_MEM:  din_s = ram_rdata_s;
            RD_PIN:  din_s = pin_rd_q;
            RD_ERR:  din_s = ERR_WORD;
            default: din_s = ZERO_WORD;
        endcase
    end

    assign o_DIN       = din_s;
    assign o_DIN_OE    = (rd_src_q != RD_IDLE);
    assign o_LD_READY  = ld_ready_s;
    assign o_POUT_STB  = pout_stb_q;
    assign o_POUT_SEL  = pout_sel_q;
    assign o_POUT_DATA = pout_data_q;
    assign o_IN_ACK    = in_ack_q;
    assign o_IN_SEL    = in_sel_q;
    assign o_BUS_ERR   = bus_err_q;

endmodule
